// File: rtl/lsu_byte_sequencer.sv
// lsu_byte_sequencer
//   Load/store initiator for a byte-wide data memory. Accepts one RV32I-style
//   load/store, issues one byte access per cycle (lowest address first),
//   reassembles load bytes with sign/zero extension and returns one response.
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   req_valid/req_ready       request handshake (ready only while idle)
//   req_we, req_funct3        1=store; 000 B, 001 H, 010 W, 100 BU, 101 HU
//   req_addr, req_wdata       byte address, store data (bytes from [7:0] up)
//   resp_valid                one-cycle completion pulse
//   resp_rdata, resp_fault    extended load data (0 for stores/faults), fault flag
//   mem_read, mem_write       byte strobes, only one active at a time
//   mem_addr, mem_wdata       current byte address and store byte
//   mem_rdata                 read byte, combinational from mem_addr
module lsu_byte_sequencer #(
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state;
  logic        we;
  logic [2:0]  funct3;
  logic [31:0] wdata;
  logic [31:0] asm_q;
  logic [1:0]  k;
  logic [1:0]  last;

  logic        illegal, misalign;
  logic [1:0]  req_last;
  logic [1:0]  k_nxt;
  logic [31:0] asm_nxt;

  // Request decode, evaluated on the live request bus while idle.
  always_comb begin
    illegal  = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
               (req_we && req_funct3[2]);
    misalign = ALIGN_CHECK &&
               (((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00)));
    case (req_funct3[1:0])
      2'b00:   req_last = 2'd0;
      2'b01:   req_last = 2'd1;
      default: req_last = 2'd3;
    endcase
  end

  // Assembly register with the byte arriving this cycle merged in, so the
  // final byte can feed the response without an extra cycle.
  always_comb begin
    k_nxt   = k + 2'd1;
    asm_nxt = asm_q;
    asm_nxt[8*k +: 8] = mem_rdata;
  end

  function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      3'b000:  extend = {{24{d[7]}}, d[7:0]};
      3'b100:  extend = {24'h0, d[7:0]};
      3'b001:  extend = {{16{d[15]}}, d[15:0]};
      3'b101:  extend = {16'h0, d[15:0]};
      default: extend = d;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_fault <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      we         <= 1'b0;
      funct3     <= '0;
      wdata      <= '0;
      asm_q      <= '0;
      k          <= '0;
      last       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we        <= req_we;
            funct3    <= req_funct3;
            wdata     <= req_wdata;
            last      <= req_last;
            req_ready <= 1'b0;
            if (illegal || misalign) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_fault <= 1'b1;
              resp_rdata <= '0;
            end else begin
              state     <= ACCESS;
              asm_q     <= '0;
              k         <= '0;
              mem_read  <= !req_we;
              mem_write <= req_we;
              mem_addr  <= req_addr;
              mem_wdata <= req_wdata[7:0];
            end
          end
        end
        ACCESS: begin
          if (!we) asm_q <= asm_nxt;
          if (k == last) begin
            state      <= RESP;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            resp_valid <= 1'b1;
            resp_rdata <= we ? 32'h0 : extend(funct3, asm_nxt);
          end else begin
            k         <= k_nxt;
            mem_addr  <= mem_addr + 32'd1;   // wraps naturally mod 2^32
            mem_wdata <= wdata[8*k_nxt +: 8];
          end
        end
        RESP: begin
          state      <= IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          resp_rdata <= '0;
          resp_fault <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
